// File: rtl/l1_cache_control_if.sv
// CPU, datapath and L2 signals seen by the L1 cache controller.
// The controller takes the master modport; the datapath/CPU/L2 side takes the slave modport.
interface l1_cache_control_if;
    // CPU side
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    // Datapath status for the indexed set
    logic       hit0;
    logic       hit1;
    logic       v_out0;
    logic       v_out1;
    logic       d_out0;
    logic       d_out1;
    logic       lru_out;
    // Array write controls
    logic       load_lru;
    logic       lru_in;
    logic       load_TD0;
    logic       load_TD1;
    logic       load_v0;
    logic       load_v1;
    logic       load_d0;
    logic       load_d1;
    logic       v_in0;
    logic       v_in1;
    logic       d_in0;
    logic       d_in1;
    logic       l2wdata_sel;
    logic [1:0] l2addr_sel;
    // L2 side
    logic       l2_read;
    logic       l2_write;
    logic       l2_resp;

    modport master (
        input  mem_read, mem_write, hit0, hit1, v_out0, v_out1, d_out0, d_out1,
               lru_out, l2_resp,
        output mem_resp, load_lru, lru_in, load_TD0, load_TD1, load_v0, load_v1,
               load_d0, load_d1, v_in0, v_in1, d_in0, d_in1, l2wdata_sel,
               l2addr_sel, l2_read, l2_write
    );

    modport slave (
        output mem_read, mem_write, hit0, hit1, v_out0, v_out1, d_out0, d_out1,
               lru_out, l2_resp,
        input  mem_resp, load_lru, lru_in, load_TD0, load_TD1, load_v0, load_v1,
               load_d0, load_d1, v_in0, v_in1, d_in0, d_in1, l2wdata_sel,
               l2addr_sel, l2_read, l2_write
    );
endinterface

// File: rtl/l1_cache_control.sv
// Two-way L1 cache controller: zero-wait hits, write-back of dirty victims, line allocation
// from L2, and saturating hit/miss event counters.
module l1_cache_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    l1_cache_control_if.master      bus,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count
);

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StAllocate
    } state_e;

    state_e           state_q, state_d;
    logic             vic_q, vic_d;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;
    logic             hit_inc, miss_inc;

    logic req, hit, hw, victim_dirty;

    assign req = bus.mem_read | bus.mem_write;
    assign hit = bus.hit0 | bus.hit1;
    // Both tag matches set is illegal; way0 wins.
    assign hw  = bus.hit1 & ~bus.hit0;
    assign victim_dirty = bus.lru_out ? (bus.v_out1 & bus.d_out1) : (bus.v_out0 & bus.d_out0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            vic_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vic_q   <= vic_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        vic_d           = vic_q;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;
        bus.mem_resp    = 1'b0;
        bus.load_lru    = 1'b0;
        bus.lru_in      = 1'b0;
        bus.load_TD0    = 1'b0;
        bus.load_TD1    = 1'b0;
        bus.load_v0     = 1'b0;
        bus.load_v1     = 1'b0;
        bus.load_d0     = 1'b0;
        bus.load_d1     = 1'b0;
        bus.v_in0       = 1'b0;
        bus.v_in1       = 1'b0;
        bus.d_in0       = 1'b0;
        bus.d_in1       = 1'b0;
        bus.l2wdata_sel = 1'b0;
        bus.l2addr_sel  = 2'd0;
        bus.l2_read     = 1'b0;
        bus.l2_write    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req && hit) begin
                    bus.mem_resp    = 1'b1;
                    bus.load_lru    = 1'b1;
                    bus.lru_in      = ~hw;
                    bus.l2wdata_sel = hw;
                    hit_inc         = 1'b1;
                    // Write hit: mark the line valid+dirty and let the writelogic merge the word.
                    if (bus.mem_write) begin
                        if (hw) begin
                            bus.load_TD1 = 1'b1;
                            bus.load_d1  = 1'b1;
                            bus.d_in1    = 1'b1;
                            bus.load_v1  = 1'b1;
                            bus.v_in1    = 1'b1;
                        end else begin
                            bus.load_TD0 = 1'b1;
                            bus.load_d0  = 1'b1;
                            bus.d_in0    = 1'b1;
                            bus.load_v0  = 1'b1;
                            bus.v_in0    = 1'b1;
                        end
                    end
                end else if (req) begin
                    vic_d    = bus.lru_out;
                    miss_inc = 1'b1;
                    state_d  = victim_dirty ? StWriteback : StAllocate;
                end
            end

            StWriteback: begin
                bus.l2_write    = 1'b1;
                bus.l2wdata_sel = vic_q;
                bus.l2addr_sel  = vic_q ? 2'd2 : 2'd1;
                if (bus.l2_resp) begin
                    state_d = StAllocate;
                end
            end

            StAllocate: begin
                bus.l2_read    = 1'b1;
                bus.l2addr_sel = 2'd0;
                if (bus.l2_resp) begin
                    if (vic_q) begin
                        bus.load_TD1 = 1'b1;
                        bus.load_v1  = 1'b1;
                        bus.v_in1    = 1'b1;
                        bus.load_d1  = 1'b1;
                        bus.d_in1    = 1'b0;
                    end else begin
                        bus.load_TD0 = 1'b1;
                        bus.load_v0  = 1'b1;
                        bus.v_in0    = 1'b1;
                        bus.load_d0  = 1'b1;
                        bus.d_in0    = 1'b0;
                    end
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase

        // Reset must silence every strobe immediately, not just at the next edge.
        if (!reset_n) begin
            hit_inc         = 1'b0;
            miss_inc        = 1'b0;
            bus.mem_resp    = 1'b0;
            bus.load_lru    = 1'b0;
            bus.lru_in      = 1'b0;
            bus.load_TD0    = 1'b0;
            bus.load_TD1    = 1'b0;
            bus.load_v0     = 1'b0;
            bus.load_v1     = 1'b0;
            bus.load_d0     = 1'b0;
            bus.load_d1     = 1'b0;
            bus.v_in0       = 1'b0;
            bus.v_in1       = 1'b0;
            bus.d_in0       = 1'b0;
            bus.d_in1       = 1'b0;
            bus.l2wdata_sel = 1'b0;
            bus.l2addr_sel  = 2'd0;
            bus.l2_read     = 1'b0;
            bus.l2_write    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (miss_inc && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_l1_cache_control.sv
// Randomized transaction-level bench for l1_cache_control; a second instance with 2-bit
// counters sees identical traffic to exercise counter saturation.
module tb_l1_cache_control;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] hit_count, miss_count;
    logic [1:0]  hit_count_s, miss_count_s;

    l1_cache_control_if bus ();
    l1_cache_control_if bus_s ();

    l1_cache_control #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    l1_cache_control #(.CNT_W(2)) dut_s (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus_s),
        .hit_count  (hit_count_s),
        .miss_count (miss_count_s)
    );

    assign bus_s.mem_read  = bus.mem_read;
    assign bus_s.mem_write = bus.mem_write;
    assign bus_s.hit0      = bus.hit0;
    assign bus_s.hit1      = bus.hit1;
    assign bus_s.v_out0    = bus.v_out0;
    assign bus_s.v_out1    = bus.v_out1;
    assign bus_s.d_out0    = bus.d_out0;
    assign bus_s.d_out1    = bus.d_out1;
    assign bus_s.lru_out   = bus.lru_out;
    assign bus_s.l2_resp   = bus.l2_resp;

    // Output vector bit positions
    localparam int B_RESP = 17, B_LLRU = 16, B_LRUIN = 15, B_TD0 = 14, B_V0 = 12, B_D0 = 10;
    localparam int B_VIN0 = 8, B_DIN0 = 6, B_WSEL = 4, B_ADDR = 2, B_RD = 1, B_WR = 0;
    localparam logic [17:0] CARE_BASE = 18'h3_7E03;

    int n_tests = 0;
    int n_fail  = 0;
    int m_hits  = 0;
    int m_miss  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] outs();
        return {bus.mem_resp, bus.load_lru, bus.lru_in, bus.load_TD0, bus.load_TD1,
                bus.load_v0, bus.load_v1, bus.load_d0, bus.load_d1, bus.v_in0, bus.v_in1,
                bus.d_in0, bus.d_in1, bus.l2wdata_sel, bus.l2addr_sel, bus.l2_read,
                bus.l2_write};
    endfunction

    function automatic logic [31:0] sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic step(input string tag, input logic [17:0] exp, input logic [17:0] care);
        @(negedge clk);
        check(tag, 32'(outs() & care), 32'(exp & care));
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".hit_count"},    32'(hit_count),    sat(m_hits, 65535));
        check({tag, ".miss_count"},   32'(miss_count),   sat(m_miss, 65535));
        check({tag, ".hit_count_s"},  32'(hit_count_s),  sat(m_hits, 3));
        check({tag, ".miss_count_s"}, 32'(miss_count_s), sat(m_miss, 3));
    endtask

    task automatic noise();
        {bus.hit0, bus.hit1, bus.lru_out} = 3'($urandom);
        {bus.v_out0, bus.v_out1, bus.d_out0, bus.d_out1} = 4'($urandom);
    endtask

    // Expected outputs for a hit served on the given way.
    task automatic hit_cycle(input string tag, input bit wr, input bit way);
        logic [17:0] exp, care;
        exp  = '0;
        care = CARE_BASE;
        exp[B_RESP]  = 1'b1;
        exp[B_LLRU]  = 1'b1;
        exp[B_LRUIN] = ~way;
        exp[B_WSEL]  = way;
        care[B_LRUIN] = 1'b1;
        care[B_WSEL]  = 1'b1;
        if (wr) begin
            exp[B_TD0 - way]  = 1'b1;
            exp[B_V0 - way]   = 1'b1;
            exp[B_D0 - way]   = 1'b1;
            exp[B_VIN0 - way] = 1'b1;
            exp[B_DIN0 - way] = 1'b1;
            care[B_VIN0 - way] = 1'b1;
            care[B_DIN0 - way] = 1'b1;
        end
        step(tag, exp, care);
        m_hits++;
    endtask

    task automatic run_txn(input bit wr, input bit rd, input bit is_hit, input bit [1:0] hp,
                           input bit lru, input bit [1:0] v, input bit [1:0] d,
                           input int lw, input int lr, input bit drop);
        logic [17:0] exp, care;
        bit dirty;
        bus.mem_write = wr;
        bus.mem_read  = rd;
        bus.l2_resp   = 1'b0;
        if (is_hit) begin
            noise();
            bus.hit0 = hp[0];
            bus.hit1 = hp[1];
            hit_cycle("hit", wr, hp[0] ? 1'b0 : 1'b1);
        end else begin
            bus.hit0 = 1'b0;
            bus.hit1 = 1'b0;
            bus.lru_out = lru;
            {bus.v_out1, bus.v_out0} = v;
            {bus.d_out1, bus.d_out0} = d;
            dirty = v[lru] & d[lru];
            step("miss_idle", '0, CARE_BASE);
            m_miss++;
            if (drop) begin
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
            if (dirty) begin
                for (int i = 0; i < lw; i++) begin
                    noise();
                    bus.l2_resp = (i == lw - 1);
                    exp = '0;
                    exp[B_WR] = 1'b1;
                    exp[B_WSEL] = lru;
                    exp[B_ADDR +: 2] = lru ? 2'd2 : 2'd1;
                    care = CARE_BASE | 18'h0001C;
                    step("writeback", exp, care);
                end
            end
            for (int i = 0; i < lr; i++) begin
                noise();
                bus.l2_resp = (i == lr - 1);
                exp  = '0;
                care = CARE_BASE | 18'h0000C;
                exp[B_RD] = 1'b1;
                if (i == lr - 1) begin
                    exp[B_TD0 - lru]  = 1'b1;
                    exp[B_V0 - lru]   = 1'b1;
                    exp[B_D0 - lru]   = 1'b1;
                    exp[B_VIN0 - lru] = 1'b1;
                    care[B_VIN0 - lru] = 1'b1;
                    care[B_DIN0 - lru] = 1'b1;
                end
                step("allocate", exp, care);
            end
            bus.l2_resp = 1'b0;
            if (!drop) begin
                noise();
                bus.hit0 = ~lru;
                bus.hit1 = lru;
                hit_cycle("refill_hit", wr, lru);
            end else begin
                noise();
                bus.l2_resp = 1'($urandom);
                step("idle_after_drop", '0, CARE_BASE);
                bus.l2_resp = 1'b0;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        noise();
        step("idle", '0, CARE_BASE);
        check_counters("txn");
    endtask

    initial begin
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b0;
        bus.hit0      = 1'b1;
        bus.hit1      = 1'b0;
        bus.v_out0    = 1'b0;
        bus.v_out1    = 1'b0;
        bus.d_out0    = 1'b0;
        bus.d_out1    = 1'b0;
        bus.lru_out   = 1'b0;
        bus.l2_resp   = 1'b0;

        // Strobes must be quiet under reset even with a hitting request present.
        #12;
        check("reset_outs", 32'(outs()), 32'd0);
        check_counters("reset");
        bus.mem_read = 1'b0;
        bus.hit0     = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_txn(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1, 1, 1'b0); // read hit way1
        run_txn(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1, 1, 1'b0); // write hit way0
        run_txn(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 2'b11, 2'b11, 1, 1, 1'b0); // both hit -> way0
        run_txn(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1, 3, 1'b0); // clean miss way1
        run_txn(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01, 2, 2, 1'b0); // dirty miss way0
        run_txn(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b10, 3, 1, 1'b0); // dirty write miss
        run_txn(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b11, 2'b10, 2, 2, 1'b1); // dropped mid-miss

        for (int t = 0; t < 200; t++) begin
            int op;
            op = $urandom_range(0, 2);
            run_txn(op != 0, op != 1, 1'($urandom), 2'($urandom_range(1, 3)), 1'($urandom),
                    2'($urandom), 2'($urandom), $urandom_range(1, 4), $urandom_range(1, 4),
                    ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset in the middle of an allocate.
        bus.mem_read = 1'b1;
        bus.hit0 = 1'b0;
        bus.hit1 = 1'b0;
        bus.lru_out = 1'b0;
        bus.v_out0 = 1'b0;
        bus.v_out1 = 1'b0;
        step("pre_reset_miss", '0, CARE_BASE);
        m_miss++;
        #2;
        check("alloc_l2_read", 32'(bus.l2_read), 32'd1);
        reset_n = 1'b0;
        bus.hit1 = 1'b1;
        #1;
        check("async_l2_read", 32'(bus.l2_read), 32'd0);
        check("async_outs", 32'(outs()), 32'd0);
        m_hits = 0;
        m_miss = 0;
        check_counters("async_reset");
        bus.mem_read = 1'b0;
        bus.hit1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus.l2_resp = 1'b1;
        step("stray_l2_resp", '0, CARE_BASE);
        bus.l2_resp = 1'b0;
        step("post_reset_idle", '0, CARE_BASE);
        check_counters("post_reset");

        // Five hits: the 2-bit counters stick at 3.
        for (int i = 0; i < 5; i++) begin
            run_txn(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1, 1, 1'b0);
        end
        check("sat_hit_count_s", 32'(hit_count_s), 32'd3);
        check("sat_hit_count", 32'(hit_count), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
